// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
//   Shared types and helpers for the serial-in/parallel-out packer family.
//   - pack_order_e : order in which beats fill an output word
//   - ratio()      : beats per output word
//   - W_SYM/W_WORD : default beat/word widths used by the decoder front end
// ---------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } pack_order_e;

    localparam int W_SYM  = 1;
    localparam int W_WORD = 8;

    function automatic int ratio(input int w_in, input int w_out);
        return w_out / w_in;
    endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// ---------------------------------------------------------------------------
// sipo_out_slot
//   One-entry valid/ready holding register. A load and a drain on the same
//   edge replace the word without a bubble. i_clear empties the slot but
//   leaves the data bits untouched.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          synchronous flush (priority over load/drain)
//   i_load, i_data   write a new word into the slot
//   i_ready          downstream takes the current word
//   o_valid, o_data  slot contents
//   o_done           one-cycle pulse after each load
// ---------------------------------------------------------------------------
module sipo_out_slot #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_done
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_done;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_load) begin
            // The caller only loads when the slot is empty or draining,
            // so a held word is never overwritten.
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_done  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_done  = r_done;

endmodule

// File: rtl/sipo_stream_packer.sv
// ---------------------------------------------------------------------------
// sipo_stream_packer
//   Packs W_IN-bit beats into W_OUT-bit words, LSB-first or MSB-first, with
//   valid/ready on both sides and a one-word output slot so packing of the
//   next word proceeds while the previous one waits downstream.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_clear                 flush partial word and output slot
//   i_msb_first             fill order, sampled on the first beat of a word
//   i_valid, i_data         input beat, o_ready accepts it
//   o_valid, o_data         completed word, i_ready drains it
//   o_done                  one-cycle pulse when a word enters the slot
//   o_fill                  beats held in the partial word
// ---------------------------------------------------------------------------
module sipo_stream_packer
    import sipo_pkg::*;
#(
    parameter int W_IN  = W_SYM,
    parameter int W_OUT = W_WORD
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_clear,
    input  logic                                 i_msb_first,
    input  logic                                 i_valid,
    input  logic [W_IN-1:0]                      i_data,
    output logic                                 o_ready,
    output logic                                 o_valid,
    output logic [W_OUT-1:0]                     o_data,
    input  logic                                 i_ready,
    output logic                                 o_done,
    output logic [$clog2(ratio(W_IN, W_OUT))-1:0] o_fill
);

    localparam int RATIO = ratio(W_IN, W_OUT);
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    if ((W_OUT % W_IN) != 0) begin : g_bad_width
        $error("sipo_stream_packer: W_OUT (%0d) must be a multiple of W_IN (%0d)", W_OUT, W_IN);
    end
    if (RATIO < 2) begin : g_bad_ratio
        $error("sipo_stream_packer: W_OUT/W_IN must be at least 2");
    end

    logic [CNT_W-1:0] r_count;
    logic [W_OUT-1:0] r_shift;
    pack_order_e      r_mode;

    logic             w_last;
    logic             w_accept;
    logic             w_load;
    pack_order_e      w_mode;
    logic [W_OUT-1:0] w_beat_ext;
    logic [W_OUT-1:0] w_word;
    int               w_pos;

    assign w_last = (r_count == LAST);

    // The completing beat waits only while the slot holds a word that is
    // not leaving this cycle; earlier beats always fit in the shift register.
    assign o_ready  = ~w_last | ~o_valid | i_ready;
    assign w_accept = i_valid & o_ready & ~i_clear;
    assign w_load   = w_accept & w_last;

    // The first beat of a word uses the live order input; later beats use
    // the order latched with that first beat.
    assign w_mode     = (r_count == '0) ? pack_order_e'(i_msb_first) : r_mode;
    assign w_beat_ext = W_OUT'(i_data);

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_pos  = 0;
        w_word = r_shift;
        if (w_mode == MSB_FIRST) begin
            w_pos = W_OUT - (int'(r_count) + 1) * W_IN;
        end else begin
            w_pos = int'(r_count) * W_IN;
        end
        // Includes the current beat, so the completing beat's word is
        // ready for the slot on the same edge.
        w_word = r_shift | (w_beat_ext << w_pos);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_shift <= '0;
            r_mode  <= LSB_FIRST;
        end else if (i_clear) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            if (r_count == '0) begin
                r_mode <= pack_order_e'(i_msb_first);
            end
            if (w_last) begin
                r_count <= '0;
                r_shift <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_shift <= w_word;
            end
        end
    end

    assign o_fill = r_count;

    sipo_out_slot #(
        .W(W_OUT)
    ) u_slot (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_load  (w_load),
        .i_data  (w_word),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_done  (o_done)
    );

endmodule
